// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM-stage data-memory controller. It turns each decoded memory op
//   (mem_read / mem_write / mem_byte_enable) into one held request on the
//   data-memory port, waits for the one-cycle response and stalls the
//   pipeline until the access completes.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     defined   : ACCESS aborts after TIMEOUT_CYCLES cycles without a response,
//                 setting the sticky timeout_err flag.
//     undefined : ACCESS waits indefinitely; timeout_err is tied to 0.
//
// Parameters
//   WIDTH          data/address width
//   TIMEOUT_CYCLES ACCESS cycles before abort (only with MEM_TIMEOUT_EN)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/read/write       MEM-stage instruction valid and direction
//   req_byte_enable            byte lanes of the op
//   req_addr, req_wdata        MAR / MDR values
//   dmem_read/write            registered strobes to data memory
//   dmem_byte_enable/address/wdata  held request fields
//   dmem_resp, dmem_rdata      completion pulse and load data
//   stall                      hold pipeline registers this cycle
//   rdata, rdata_valid         captured load data, valid one cycle in DONE
//   timeout_err                sticky access-timeout flag
//
// States
//   state     | meaning
//   ST_IDLE   | no access in flight; a memory op here raises stall at once
//   ST_ACCESS | strobe held on dmem port until dmem_resp (or timeout)
//   ST_DONE   | one cycle; stall released, load data presented
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [1:0]       req_byte_enable,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_byte_enable,
  output logic [WIDTH-1:0] dmem_address,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_resp,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             stall,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_mem_op;
  logic             w_stall;
  logic             w_start;
  logic             w_finish;
  logic             w_abort;

  logic             r_dmem_read;
  logic             r_dmem_write;
  logic [1:0]       r_be;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_op_read;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rdata_valid;
  logic             r_timeout_err;

  assign w_mem_op = req_valid & (req_read | req_write);
  assign w_start  = (r_state == ST_IDLE) & w_mem_op;

`ifdef MEM_TIMEOUT_EN
  localparam int TCW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [TCW-1:0] r_tcount;

  // Abort on the edge that would bring the count to TIMEOUT_CYCLES, so the
  // strobe is held for exactly TIMEOUT_CYCLES cycles. A response arriving in
  // that same cycle wins and completes normally.
  assign w_abort = (r_state == ST_ACCESS) & ~dmem_resp & (r_tcount == TC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcount <= '0;
    end else if (w_start) begin
      r_tcount <= '0;
    end else if ((r_state == ST_ACCESS) && !dmem_resp) begin
      r_tcount <= r_tcount + 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  assign w_finish = (r_state == ST_ACCESS) & (dmem_resp | w_abort);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_stall = 1'b1;
        if (dmem_resp || w_abort) w_state_nxt = ST_DONE;
      end
      // Unconditional return: the pipeline advances on the DONE edge, so the
      // op just completed can never be seen again in IDLE.
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dmem_read   <= 1'b0;
      r_dmem_write  <= 1'b0;
      r_be          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_op_read     <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      if (w_start) begin
        // Read+write together is illegal; the write wins.
        r_dmem_read  <= req_read & ~req_write;
        r_dmem_write <= req_write;
        r_op_read    <= req_read & ~req_write;
        r_be         <= req_byte_enable;
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
      end
      if (w_finish) begin
        r_dmem_read   <= 1'b0;
        r_dmem_write  <= 1'b0;
        r_rdata_valid <= r_op_read;
        if (r_op_read) r_rdata <= dmem_resp ? dmem_rdata : '0;
        if (w_abort)   r_timeout_err <= 1'b1;
      end
    end
  end

  assign dmem_read        = r_dmem_read;
  assign dmem_write       = r_dmem_write;
  assign dmem_byte_enable = r_be;
  assign dmem_address     = r_addr;
  assign dmem_wdata       = r_wdata;
  assign stall            = w_stall;
  assign rdata            = r_rdata;
  assign rdata_valid      = r_rdata_valid;
  assign timeout_err      = r_timeout_err;

endmodule
